sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Single-clock, parametrised FIFO for same-domain buffering. It is the single-clock counterpart of the dual-clock FIFO and adds features that FIFO lacks: a selectable read mode (registered or first-word-fall-through), an exact fill level, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between producer and consumer logic that share one clock, where the gray-code synchroniser path is unnecessary.

## Interface

- BITS, 32, width of each entry
- SIZE, 16, number of entries; power of two and >1, otherwise `$fatal` at elaboration
- MODE, FIFO_STD, read mode: FIFO_STD gives registered read data; FIFO_FWFT gives show-ahead
- AF_TH, SIZE-1, almost-full threshold; legal range 1..SIZE, otherwise `$fatal`
- AE_TH, 1, almost-empty threshold; legal range 0..SIZE-1, otherwise `$fatal`

- clk  in  1  clock; single clock for the whole block
- rst_n  in  1  reset; asynchronous, active-low
- p_flush  in  1  synchronous flush: empties the FIFO
- p_write_en  in  1  write request
- p_write_data  in  BITS  write data
- p_write_full  out  1  FIFO full
- p_almost_full  out  1  level >= AF_TH
- p_read_en  in  1  read request (pop)
- p_read_data  out  BITS  read data
- p_read_empty  out  1  FIFO empty
- p_almost_empty  out  1  level <= AE_TH
- p_level  out  $clog2(SIZE)+1  current occupancy, 0..SIZE
- p_err_clr  in  1  clears the sticky error flags
- p_overflow  out  1  sticky flag: a write was rejected
- p_underflow  out  1  sticky flag: a read was rejected

## Operation

- State:
  - entry array `r_fifo`, SIZE entries of BITS
  - write and read pointers, each $clog2(SIZE) bits, wrapping naturally at SIZE-1 -> 0
  - registered level counter, $clog2(SIZE)+1 bits
- Accept rules, evaluated on the registered state:
  - read_acc = p_read_en && !empty
  - write_acc = p_write_en && (!full || read_acc)
- Simultaneous read and write:
  - When full, both are accepted and the level is unchanged.
  - When empty, only the write is accepted; a write cannot be read in the same cycle in either mode.
- Level update:
  - +1 on write only
  - -1 on read only
  - unchanged when both or neither are accepted
  - never exceeds SIZE and never goes below 0
- Flags are combinational from the registered level:
  - full = (level == SIZE)
  - empty = (level == 0)
  - p_almost_full = (level >= AF_TH)
  - p_almost_empty = (level <= AE_TH)
- FIFO_STD read mode:
  - On read_acc, p_read_data <= r_fifo[rd_ptr].
  - Otherwise p_read_data holds its value.
- FIFO_FWFT read mode:
  - p_read_data = r_fifo[rd_ptr] combinationally, valid whenever !empty.
  - Contents are don't-care while empty.
  - A read pops the head.
- Flush:
  - p_flush has priority over read and write in the same cycle.
  - Pointers and level go to 0; the array contents are untouched.
  - In FIFO_STD mode p_read_data holds.
  - Flush does not set the error flags.
- Error flags:
  - p_overflow is set when p_write_en && !write_acc && !p_flush.
  - p_underflow is set when p_read_en && !read_acc && !p_flush.
  - p_err_clr clears both flags.
  - If a set and a clear occur in the same cycle, the set wins.

## Timing

- Reset values (asynchronous):
  - pointers 0, level 0
  - p_read_data 0 (FIFO_STD)
  - p_overflow 0, p_underflow 0
  - giving p_read_empty=1, p_write_full=0, p_almost_empty=1 (since AE_TH >= 0), p_almost_full=0 (since AF_TH >= 1)
  - The array is not reset.
- Write-to-visibility: data written at edge N is readable at edge N+1, when empty deasserts and level increments.
- FIFO_STD read latency: 1 cycle. A read requested at edge N has its data on p_read_data after edge N.
- FIFO_FWFT read latency: 0 cycles. The head is visible before the pop edge.
- All status outputs update on the same edge that changes the level.
- Reset mid-operation: all state returns to the reset values immediately, with no pending writes completing.

## Structure

- Package `sync_fifo_pkg`:
  - `typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e`
  - a `is_pow2` constant function, shared with the dual-clock FIFO's size check
- Sub-module `sync_fifo_prog_sva`, instantiated inside the block. It asserts:
  - level <= SIZE
  - !(full && empty)
  - the level delta matches write_acc/read_acc
  - the pointer difference equals the level modulo SIZE
  - no pointer move while empty/full without the matching accept

## Test plan

- Fill: SIZE=16, MODE=STD, 16 writes of 0..15 -> p_level reaches 16, p_write_full=1, p_almost_full=1 from level 15; a 17th write sets p_overflow and leaves the data unchanged.
- Drain: drain the full FIFO -> p_read_data reads 0..15 in order, each 1 cycle after its read; p_read_empty=1 after the 16th read; one further read sets p_underflow.
- Simultaneous at full: with level=16, p_write_en=p_read_en=1 for 3 cycles -> level stays 16, no overflow, order preserved across pointer wrap.
- FWFT: MODE=FWFT, write 0xA5 -> next cycle p_read_data=0xA5 with p_read_en=0; a pop -> p_read_empty=1.
- Flush: at level=5, assert p_flush together with p_write_en and p_read_en -> next cycle level=0, empty=1, no error flags set; then write 0x3C, read -> 0x3C.
- Thresholds and reset: AF_TH=12, AE_TH=3 -> almost_empty deasserts at level 4, almost_full asserts at level 12; asserting rst_n=0 mid-stream at level 7 -> immediate empty, level 0, errors 0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and helpers for the single- and dual-clock FIFOs.
//   fifo_mode_e : read-port behaviour (registered vs. show-ahead)
//   is_pow2     : constant function used for elaboration-time size checks
package sync_fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_sva.sv
// sync_fifo_prog_sva: structural invariants of sync_fifo_prog.
//   clk, rst_n          : block clock / async active-low reset
//   flush               : flush request of the current cycle
//   write_acc, read_acc : raw accept terms (before flush gating)
//   level, wr_ptr, rd_ptr : registered FIFO state
module sync_fifo_prog_sva #(
  parameter int SIZE = 16,
  parameter int AW   = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  input logic          write_acc,
  input logic          read_acc,
  input logic [AW:0]   level,
  input logic [AW-1:0] wr_ptr,
  input logic [AW-1:0] rd_ptr
);

  logic full, empty;
  assign full  = (level == (AW+1)'(SIZE));
  assign empty = (level == '0);

  a_lvl_max: assert property (@(posedge clk) disable iff (!rst_n) level <= (AW+1)'(SIZE));
  a_flags:   assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));

  // pointer distance is the level modulo SIZE (full and empty alias to 0)
  a_ptr_lvl: assert property (@(posedge clk) disable iff (!rst_n)
    AW'(wr_ptr - rd_ptr) == level[AW-1:0]);

  a_delta: assert property (@(posedge clk) disable iff (!rst_n)
    $past(rst_n) && !$past(flush) |->
      level == $past(level) + (AW+1)'($past(write_acc)) - (AW+1)'($past(read_acc)));

  a_flush: assert property (@(posedge clk) disable iff (!rst_n)
    $past(rst_n) && $past(flush) |-> level == '0 && wr_ptr == '0 && rd_ptr == '0);

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    $past(rst_n) && $past(empty) && !$past(flush) |-> rd_ptr == $past(rd_ptr));

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    $past(rst_n) && $past(full) && !$past(read_acc) && !$past(flush) |-> wr_ptr == $past(wr_ptr));

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with selectable read mode, exact fill
// level, programmable almost-full/almost-empty, synchronous flush and sticky
// overflow/underflow flags.
//   p_flush                  : sync flush (wins over read/write)
//   p_write_en/_data/_full   : write port
//   p_almost_full            : level >= AF_TH
//   p_read_en/_data/_empty   : read port (STD: registered, FWFT: show-ahead)
//   p_almost_empty           : level <= AE_TH
//   p_level                  : occupancy 0..SIZE
//   p_err_clr/p_overflow/p_underflow : sticky error flags and their clear
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int         BITS  = 32,
  parameter int         SIZE  = 16,
  parameter fifo_mode_e MODE  = FIFO_STD,
  parameter int         AF_TH = SIZE - 1,
  parameter int         AE_TH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p_flush,
  input  logic                 p_write_en,
  input  logic [BITS-1:0]      p_write_data,
  output logic                 p_write_full,
  output logic                 p_almost_full,
  input  logic                 p_read_en,
  output logic [BITS-1:0]      p_read_data,
  output logic                 p_read_empty,
  output logic                 p_almost_empty,
  output logic [$clog2(SIZE):0] p_level,
  input  logic                 p_err_clr,
  output logic                 p_overflow,
  output logic                 p_underflow
);

  localparam int AW = $clog2(SIZE);
  localparam int LW = AW + 1;

  if (SIZE < 2 || !is_pow2(SIZE)) begin : g_bad_size
    $fatal(1, "sync_fifo_prog: SIZE must be a power of two > 1");
  end
  if (AF_TH < 1 || AF_TH > SIZE) begin : g_bad_af
    $fatal(1, "sync_fifo_prog: AF_TH out of range 1..SIZE");
  end
  if (AE_TH < 0 || AE_TH > SIZE - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_prog: AE_TH out of range 0..SIZE-1");
  end

  logic [BITS-1:0] r_fifo [SIZE];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d, udf_q, udf_d;
  logic            full, empty, read_acc, write_acc, do_wr, do_rd;

  assign full      = (level_q == LW'(SIZE));
  assign empty     = (level_q == '0);
  assign read_acc  = p_read_en && !empty;
  // at full a write is still taken when a pop frees the slot in the same cycle
  assign write_acc = p_write_en && (!full || read_acc);
  assign do_wr     = write_acc && !p_flush;
  assign do_rd     = read_acc && !p_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (p_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_wr && !do_rd)      level_d = level_q + 1'b1;
      else if (do_rd && !do_wr) level_d = level_q - 1'b1;
    end
    // set beats clear in the same cycle
    ovf_d = (ovf_q && !p_err_clr) || (p_write_en && !write_acc && !p_flush);
    udf_d = (udf_q && !p_err_clr) || (p_read_en && !read_acc && !p_flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // storage is not reset
  always_ff @(posedge clk) begin
    if (do_wr) r_fifo[wr_ptr_q] <= p_write_data;
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign p_read_data = r_fifo[rd_ptr_q];
  end else begin : g_std
    logic [BITS-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rdata_q <= '0;
      else if (do_rd) rdata_q <= r_fifo[rd_ptr_q];
    end
    assign p_read_data = rdata_q;
  end

  assign p_write_full   = full;
  assign p_read_empty   = empty;
  assign p_almost_full  = (level_q >= LW'(AF_TH));
  assign p_almost_empty = (level_q <= LW'(AE_TH));
  assign p_level        = level_q;
  assign p_overflow     = ovf_q;
  assign p_underflow    = udf_q;

  sync_fifo_prog_sva #(.SIZE(SIZE), .AW(AW)) u_sva (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (p_flush),
    .write_acc (write_acc),
    .read_acc  (read_acc),
    .level     (level_q),
    .wr_ptr    (wr_ptr_q),
    .rd_ptr    (rd_ptr_q)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed bench for sync_fifo_prog. Three instances:
// STD defaults, FWFT, and STD with AF_TH=12/AE_TH=3.
module tb_sync_fifo_prog;
  import sync_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // STD instance
  logic s_flush = 0, s_we = 0, s_re = 0, s_clr = 0;
  logic [31:0] s_wd = '0, s_rd;
  logic s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [4:0] s_lvl;
  // FWFT instance
  logic f_flush = 0, f_we = 0, f_re = 0, f_clr = 0;
  logic [31:0] f_wd = '0, f_rd;
  logic f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [4:0] f_lvl;
  // threshold instance
  logic t_flush = 0, t_we = 0, t_re = 0, t_clr = 0;
  logic [31:0] t_wd = '0, t_rd;
  logic t_full, t_af, t_empty, t_ae, t_ovf, t_udf;
  logic [4:0] t_lvl;

  sync_fifo_prog u_s (
    .clk(clk), .rst_n(rst_n), .p_flush(s_flush), .p_write_en(s_we), .p_write_data(s_wd),
    .p_write_full(s_full), .p_almost_full(s_af), .p_read_en(s_re), .p_read_data(s_rd),
    .p_read_empty(s_empty), .p_almost_empty(s_ae), .p_level(s_lvl), .p_err_clr(s_clr),
    .p_overflow(s_ovf), .p_underflow(s_udf));

  sync_fifo_prog #(.MODE(FIFO_FWFT)) u_f (
    .clk(clk), .rst_n(rst_n), .p_flush(f_flush), .p_write_en(f_we), .p_write_data(f_wd),
    .p_write_full(f_full), .p_almost_full(f_af), .p_read_en(f_re), .p_read_data(f_rd),
    .p_read_empty(f_empty), .p_almost_empty(f_ae), .p_level(f_lvl), .p_err_clr(f_clr),
    .p_overflow(f_ovf), .p_underflow(f_udf));

  sync_fifo_prog #(.AF_TH(12), .AE_TH(3)) u_t (
    .clk(clk), .rst_n(rst_n), .p_flush(t_flush), .p_write_en(t_we), .p_write_data(t_wd),
    .p_write_full(t_full), .p_almost_full(t_af), .p_read_en(t_re), .p_read_data(t_rd),
    .p_read_empty(t_empty), .p_almost_empty(t_ae), .p_level(t_lvl), .p_err_clr(t_clr),
    .p_overflow(t_ovf), .p_underflow(t_udf));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // advance one edge, land 1 time unit after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state
    #3;
    chk("rst_lvl", 32'(s_lvl), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_full", 32'(s_full), 0);
    chk("rst_ae", 32'(s_ae), 1);
    chk("rst_af", 32'(s_af), 0);
    chk("rst_rd", s_rd, 0);
    chk("rst_ovf", 32'(s_ovf), 0);
    chk("rst_udf", 32'(s_udf), 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // ---- fill 0..15
    s_we = 1;
    for (int i = 0; i < 16; i++) begin
      s_wd = 32'(i);
      cyc();
      chk($sformatf("fill_lvl%0d", i), 32'(s_lvl), 32'(i + 1));
      chk($sformatf("fill_af%0d", i), 32'(s_af), (i + 1 >= 15) ? 1 : 0);
    end
    chk("fill_full", 32'(s_full), 1);
    chk("fill_ovf0", 32'(s_ovf), 0);
    s_wd = 32'hDEAD;
    cyc();
    chk("ovf_set", 32'(s_ovf), 1);
    chk("ovf_lvl", 32'(s_lvl), 16);
    s_we = 0; s_clr = 1;
    cyc();
    s_clr = 0;
    chk("ovf_clr", 32'(s_ovf), 0);

    // ---- drain: data 0..15, rejected 17th write must not appear
    s_re = 1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("drain_rd%0d", i), s_rd, 32'(i));
      chk($sformatf("drain_lvl%0d", i), 32'(s_lvl), 32'(15 - i));
    end
    chk("drain_empty", 32'(s_empty), 1);
    cyc();
    chk("udf_set", 32'(s_udf), 1);
    chk("udf_rd_hold", s_rd, 15);
    s_re = 0; s_clr = 1;
    cyc();
    s_clr = 0;
    chk("udf_clr", 32'(s_udf), 0);

    // ---- simultaneous read/write at full
    s_we = 1;
    for (int i = 0; i < 16; i++) begin
      s_wd = 32'(100 + i);
      cyc();
    end
    chk("sim_full", 32'(s_full), 1);
    s_re = 1;
    for (int i = 0; i < 3; i++) begin
      s_wd = 32'(200 + i);
      cyc();
      chk($sformatf("sim_rd%0d", i), s_rd, 32'(100 + i));
      chk($sformatf("sim_lvl%0d", i), 32'(s_lvl), 16);
      chk($sformatf("sim_ovf%0d", i), 32'(s_ovf), 0);
    end
    s_we = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("wrap_rd%0d", i), s_rd, (i < 13) ? 32'(103 + i) : 32'(200 + i - 13));
    end
    s_re = 0;
    chk("wrap_empty", 32'(s_empty), 1);

    // ---- flush with concurrent read/write
    s_we = 1;
    for (int i = 1; i <= 5; i++) begin
      s_wd = 32'(i);
      cyc();
    end
    chk("fl_pre_lvl", 32'(s_lvl), 5);
    s_flush = 1; s_re = 1; s_wd = 32'h77;
    cyc();
    s_flush = 0; s_re = 0;
    chk("fl_lvl", 32'(s_lvl), 0);
    chk("fl_empty", 32'(s_empty), 1);
    chk("fl_ovf", 32'(s_ovf), 0);
    chk("fl_udf", 32'(s_udf), 0);
    chk("fl_rd_hold", s_rd, 202);
    s_wd = 32'h3C;
    cyc();
    s_we = 0;
    chk("fl_wr_lvl", 32'(s_lvl), 1);
    s_re = 1;
    cyc();
    s_re = 0;
    chk("fl_rd", s_rd, 32'h3C);
    chk("fl_rd_empty", 32'(s_empty), 1);
    // leave an underflow set so the later reset is seen to clear it
    s_re = 1;
    cyc();
    s_re = 0;
    chk("udf_pre_rst", 32'(s_udf), 1);

    // ---- FWFT
    f_we = 1; f_wd = 32'hA5;
    cyc();
    f_we = 0;
    chk("fw_rd", f_rd, 32'hA5);
    chk("fw_nempty", 32'(f_empty), 0);
    cyc();
    chk("fw_rd_hold", f_rd, 32'hA5);
    f_re = 1;
    cyc();
    f_re = 0;
    chk("fw_pop_empty", 32'(f_empty), 1);
    f_we = 1; f_wd = 32'h11;
    cyc();
    f_wd = 32'h22;
    cyc();
    f_we = 0;
    chk("fw_head1", f_rd, 32'h11);
    f_re = 1;
    cyc();
    f_re = 0;
    chk("fw_head2", f_rd, 32'h22);
    chk("fw_lvl", 32'(f_lvl), 1);

    // ---- thresholds AF_TH=12, AE_TH=3
    t_we = 1;
    for (int i = 1; i <= 12; i++) begin
      t_wd = 32'(i);
      cyc();
      chk($sformatf("th_ae%0d", i), 32'(t_ae), (i <= 3) ? 1 : 0);
      chk($sformatf("th_af%0d", i), 32'(t_af), (i >= 12) ? 1 : 0);
    end
    t_we = 0; t_re = 1;
    for (int i = 0; i < 5; i++) cyc();
    t_re = 0;
    chk("th_lvl7", 32'(t_lvl), 7);

    // ---- async reset mid-stream with a write pending
    t_we = 1; t_wd = 32'h99;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_lvl", 32'(t_lvl), 0);
    chk("mrst_empty", 32'(t_empty), 1);
    chk("mrst_ovf", 32'(t_ovf), 0);
    chk("mrst_udf", 32'(t_udf), 0);
    chk("mrst_s_udf", 32'(s_udf), 0);
    cyc();
    chk("mrst_lvl_hold", 32'(t_lvl), 0);
    t_we = 0;
    rst_n = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
